// File: rtl/as_rv32i_hazard_ctrl.sv
// rv32i execute-stage hazard/forwarding controller: operand forwarding selects,
// ALU stall/force-stall arbitration, stall/flush perf counters and memory-wait watchdog.

module as_rv32i_hazard_fwd (
  input  logic       i_d_valid,
  input  logic       i_use,
  input  logic [4:0] i_addr,
  input  logic       i_a_valid,
  input  logic       i_a_wr_rd,
  input  logic [4:0] i_a_rd_addr,
  input  logic       i_a_rd_valid,
  input  logic       i_m_valid,
  input  logic       i_m_wr_rd,
  input  logic [4:0] i_m_rd_addr,
  input  logic       i_m_rd_valid,
  output logic [1:0] o_sel,
  output logic       o_haz
);
  logic w_chk, w_ma, w_mm;

  assign w_chk = i_d_valid & i_use & (i_addr != 5'd0);
  assign w_ma  = w_chk & i_a_valid & i_a_wr_rd & (i_a_rd_addr == i_addr);
  assign w_mm  = w_chk & i_m_valid & i_m_wr_rd & (i_m_rd_addr == i_addr);

  // A is younger than M, so an A match shadows M even when A's value is not ready
  always_comb begin
    o_sel = 2'b00;
    o_haz = 1'b0;
    if (w_ma) begin
      if (i_a_rd_valid) o_sel = 2'b01;
      else              o_haz = 1'b1;
    end else if (w_mm) begin
      if (i_m_rd_valid) o_sel = 2'b10;
      else              o_haz = 1'b1;
    end
  end
endmodule

module as_rv32i_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_d_valid,
  input  logic [4:0]       i_d_rs1_addr,
  input  logic [4:0]       i_d_rs2_addr,
  input  logic             i_d_use_rs1,
  input  logic             i_d_use_rs2,
  input  logic             i_a_valid,
  input  logic             i_a_wr_rd,
  input  logic [4:0]       i_a_rd_addr,
  input  logic             i_a_rd_valid,
  input  logic             i_change_pc,
  input  logic             i_m_valid,
  input  logic             i_m_wr_rd,
  input  logic [4:0]       i_m_rd_addr,
  input  logic             i_m_rd_valid,
  input  logic             i_m_busy,
  input  logic             i_clr,
  output logic [1:0]       o_fwd_rs1_sel,
  output logic [1:0]       o_fwd_rs2_sel,
  output logic             o_stall_alu,
  output logic             o_force_stall_alu,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count,
  output logic             o_mem_timeout
);
  localparam int NUM_OPS = 2;
  localparam int WW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] W_TO = WW'(TIMEOUT);

  typedef enum logic [1:0] {RUN = 2'b00, HAZ = 2'b01, MEMW = 2'b10, REDIR = 2'b11} state_t;

  logic [NUM_OPS-1:0][4:0] w_addr;
  logic [NUM_OPS-1:0]      w_use;
  logic [NUM_OPS-1:0][1:0] w_sel;
  logic [NUM_OPS-1:0]      w_haz;
  state_t                  w_nxt;
  logic                    w_stall, w_force;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_stall_cycles, r_flush_count;
  logic [WW-1:0]           r_wait;
  logic                    r_mem_timeout;

  assign w_addr = {i_d_rs2_addr, i_d_rs1_addr};
  assign w_use  = {i_d_use_rs2, i_d_use_rs1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    as_rv32i_hazard_fwd u_fwd (
      .i_d_valid    (i_d_valid),
      .i_use        (w_use[g]),
      .i_addr       (w_addr[g]),
      .i_a_valid    (i_a_valid),
      .i_a_wr_rd    (i_a_wr_rd),
      .i_a_rd_addr  (i_a_rd_addr),
      .i_a_rd_valid (i_a_rd_valid),
      .i_m_valid    (i_m_valid),
      .i_m_wr_rd    (i_m_wr_rd),
      .i_m_rd_addr  (i_m_rd_addr),
      .i_m_rd_valid (i_m_rd_valid),
      .o_sel        (w_sel[g]),
      .o_haz        (w_haz[g])
    );
  end

  // a taken redirect flushes D, so it overrides any stall request
  always_comb begin
    w_nxt   = RUN;
    w_stall = 1'b0;
    w_force = 1'b0;
    if (i_change_pc) begin
      w_nxt = REDIR;
    end else if (i_m_busy) begin
      w_nxt   = MEMW;
      w_stall = 1'b1;
    end else if (|w_haz) begin
      w_nxt   = HAZ;
      w_force = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= RUN;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_wait         <= '0;
      r_mem_timeout  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (i_clr) begin
        r_stall_cycles <= '0;
        r_flush_count  <= '0;
        r_wait         <= '0;
        r_mem_timeout  <= 1'b0;
      end else begin
        if ((w_nxt == HAZ || w_nxt == MEMW) && r_stall_cycles != '1)
          r_stall_cycles <= r_stall_cycles + 1'b1;
        if (i_change_pc && i_d_valid && r_flush_count != '1)
          r_flush_count <= r_flush_count + 1'b1;
        if (w_nxt == MEMW) begin
          if (r_wait != W_TO) r_wait <= r_wait + 1'b1;
          if (r_wait >= W_TO - 1'b1) r_mem_timeout <= 1'b1;
        end else begin
          r_wait <= '0;
        end
      end
    end
  end

  assign o_fwd_rs1_sel     = w_sel[0];
  assign o_fwd_rs2_sel     = w_sel[1];
  assign o_stall_alu       = w_stall & ~i_rst;
  assign o_force_stall_alu = w_force & ~i_rst;
  assign o_state           = r_state;
  assign o_stall_cycles    = r_stall_cycles;
  assign o_flush_count     = r_flush_count;
  assign o_mem_timeout     = r_mem_timeout;
endmodule

// File: tb/tb_as_rv32i_hazard_ctrl.sv
// Bench for as_rv32i_hazard_ctrl: vector table, hand sequences for multi-cycle
// corners, and random stimulus against a behavioural model.

module tb_as_rv32i_hazard_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  typedef struct {
    logic       d_valid;
    logic [4:0] rs1, rs2;
    logic       use1, use2;
    logic       a_valid, a_wr;
    logic [4:0] a_rd;
    logic       a_rdv, chg, m_valid, m_wr;
    logic [4:0] m_rd;
    logic       m_rdv, m_busy, clr;
  } in_t;

  typedef struct {
    in_t        i;
    logic [1:0] f1, f2;
    logic       st, fs;
    logic [1:0] ns;
  } tv_t;

  logic i_clk = 1'b0, i_rst = 1'b0;
  logic i_d_valid, i_d_use_rs1, i_d_use_rs2, i_a_valid, i_a_wr_rd, i_a_rd_valid;
  logic i_change_pc, i_m_valid, i_m_wr_rd, i_m_rd_valid, i_m_busy, i_clr;
  logic [4:0] i_d_rs1_addr, i_d_rs2_addr, i_a_rd_addr, i_m_rd_addr;
  logic [1:0] o_fwd_rs1_sel, o_fwd_rs2_sel, o_state;
  logic o_stall_alu, o_force_stall_alu, o_mem_timeout;
  logic [CNT_W-1:0] o_stall_cycles, o_flush_count;

  int total = 0, bad = 0;
  int m_state, m_stall, m_flush, m_wait;
  logic m_to;
  tv_t tv[14];

  as_rv32i_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_d_valid(i_d_valid),
    .i_d_rs1_addr(i_d_rs1_addr), .i_d_rs2_addr(i_d_rs2_addr),
    .i_d_use_rs1(i_d_use_rs1), .i_d_use_rs2(i_d_use_rs2),
    .i_a_valid(i_a_valid), .i_a_wr_rd(i_a_wr_rd), .i_a_rd_addr(i_a_rd_addr),
    .i_a_rd_valid(i_a_rd_valid), .i_change_pc(i_change_pc),
    .i_m_valid(i_m_valid), .i_m_wr_rd(i_m_wr_rd), .i_m_rd_addr(i_m_rd_addr),
    .i_m_rd_valid(i_m_rd_valid), .i_m_busy(i_m_busy), .i_clr(i_clr),
    .o_fwd_rs1_sel(o_fwd_rs1_sel), .o_fwd_rs2_sel(o_fwd_rs2_sel),
    .o_stall_alu(o_stall_alu), .o_force_stall_alu(o_force_stall_alu),
    .o_state(o_state), .o_stall_cycles(o_stall_cycles),
    .o_flush_count(o_flush_count), .o_mem_timeout(o_mem_timeout)
  );

  always #5 i_clk = ~i_clk;

  function automatic in_t mk(input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                             input logic u1, input logic u2, input logic av, input logic aw,
                             input logic [4:0] ard, input logic arv, input logic ch,
                             input logic mv, input logic mw, input logic [4:0] mrd,
                             input logic mrv, input logic mb);
    in_t x;
    x = '{d_valid:dv, rs1:r1, rs2:r2, use1:u1, use2:u2, a_valid:av, a_wr:aw, a_rd:ard,
          a_rdv:arv, chg:ch, m_valid:mv, m_wr:mw, m_rd:mrd, m_rdv:mrv, m_busy:mb, clr:1'b0};
    return x;
  endfunction

  // search producers youngest-first; the first writer of the register decides
  function automatic void mdl_op(input in_t x, input logic [4:0] addr, input logic use_r,
                                 output logic [1:0] sel, output logic hz);
    logic live[2], wr[2], ok[2];
    logic [4:0] rd[2];
    live = '{x.a_valid, x.m_valid};
    wr   = '{x.a_wr, x.m_wr};
    ok   = '{x.a_rdv, x.m_rdv};
    rd   = '{x.a_rd, x.m_rd};
    sel = 2'b00;
    hz  = 1'b0;
    if (!x.d_valid || !use_r || addr == 5'd0) return;
    for (int k = 0; k < 2; k++)
      if (live[k] && wr[k] && rd[k] == addr) begin
        if (ok[k]) sel = 2'(k + 1);
        else hz = 1'b1;
        return;
      end
  endfunction

  function automatic void mdl_comb(input in_t x, output logic [1:0] f1, output logic [1:0] f2,
                                   output logic st, output logic fs, output int nx);
    logic h1, h2;
    mdl_op(x, x.rs1, x.use1, f1, h1);
    mdl_op(x, x.rs2, x.use2, f2, h2);
    st = 1'b0;
    fs = 1'b0;
    nx = x.chg ? 3 : x.m_busy ? 2 : (h1 | h2) ? 1 : 0;
    st = (nx == 2);
    fs = (nx == 1);
  endfunction

  task automatic mdl_tick(input in_t x);
    logic [1:0] f1, f2;
    logic st, fs;
    int nx;
    mdl_comb(x, f1, f2, st, fs, nx);
    m_state = nx;
    if (x.clr) begin
      m_stall = 0; m_flush = 0; m_wait = 0; m_to = 1'b0;
    end else begin
      if (nx == 1 || nx == 2) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      if (x.chg && x.d_valid) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
      if (nx == 2) begin
        if (m_wait < TIMEOUT) m_wait++;
        if (m_wait >= TIMEOUT) m_to = 1'b1;
      end else m_wait = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    i_d_valid = x.d_valid; i_d_rs1_addr = x.rs1; i_d_rs2_addr = x.rs2;
    i_d_use_rs1 = x.use1; i_d_use_rs2 = x.use2;
    i_a_valid = x.a_valid; i_a_wr_rd = x.a_wr; i_a_rd_addr = x.a_rd; i_a_rd_valid = x.a_rdv;
    i_change_pc = x.chg; i_m_valid = x.m_valid; i_m_wr_rd = x.m_wr; i_m_rd_addr = x.m_rd;
    i_m_rd_valid = x.m_rdv; i_m_busy = x.m_busy; i_clr = x.clr;
  endtask

  task automatic chk_regs();
    chk("state", 32'(o_state), 32'(m_state));
    chk("stall_cycles", 32'(o_stall_cycles), 32'(m_stall));
    chk("flush_count", 32'(o_flush_count), 32'(m_flush));
    chk("mem_timeout", 32'(o_mem_timeout), 32'(m_to));
  endtask

  task automatic cycle(input in_t x);
    logic [1:0] f1, f2;
    logic st, fs;
    int nx;
    drive(x);
    #1;
    mdl_comb(x, f1, f2, st, fs, nx);
    chk("fwd_rs1", 32'(o_fwd_rs1_sel), 32'(f1));
    chk("fwd_rs2", 32'(o_fwd_rs2_sel), 32'(f2));
    chk("stall_alu", 32'(o_stall_alu), 32'(st));
    chk("force_stall", 32'(o_force_stall_alu), 32'(fs));
    @(posedge i_clk);
    mdl_tick(x);
    #1;
    chk_regs();
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0));
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 1'b0;
  endtask

  in_t idle, busy, clr_v, x;

  initial begin
    tv[0]  = '{mk(1,5,6,1,1, 1,1,5,1, 0, 0,0,0,0, 0), 2'd1, 2'd0, 1'b0, 1'b0, 2'd0};
    tv[1]  = '{mk(1,1,7,0,1, 1,1,7,0, 0, 0,0,0,0, 0), 2'd0, 2'd0, 1'b0, 1'b1, 2'd1};
    tv[2]  = '{mk(1,1,7,0,1, 0,0,0,0, 0, 1,1,7,1, 0), 2'd0, 2'd2, 1'b0, 1'b0, 2'd0};
    tv[3]  = '{mk(1,0,2,1,0, 1,1,0,0, 0, 0,0,0,0, 0), 2'd0, 2'd0, 1'b0, 1'b0, 2'd0};
    tv[4]  = '{mk(1,9,1,1,0, 1,1,9,1, 0, 1,1,9,1, 0), 2'd1, 2'd0, 1'b0, 1'b0, 2'd0};
    tv[5]  = '{mk(1,9,1,1,0, 1,1,9,1, 0, 1,1,9,0, 0), 2'd1, 2'd0, 1'b0, 1'b0, 2'd0};
    tv[6]  = '{mk(1,2,9,0,1, 1,1,9,0, 0, 1,1,9,1, 0), 2'd0, 2'd0, 1'b0, 1'b1, 2'd1};
    tv[7]  = '{mk(1,3,0,1,0, 0,0,0,0, 0, 1,1,3,0, 0), 2'd0, 2'd0, 1'b0, 1'b1, 2'd1};
    tv[8]  = '{mk(1,9,0,0,0, 1,1,9,0, 0, 0,0,0,0, 0), 2'd0, 2'd0, 1'b0, 1'b0, 2'd0};
    tv[9]  = '{mk(0,9,9,1,1, 1,1,9,0, 0, 0,0,0,0, 0), 2'd0, 2'd0, 1'b0, 1'b0, 2'd0};
    tv[10] = '{mk(1,4,0,1,0, 1,0,4,0, 0, 1,1,4,1, 0), 2'd2, 2'd0, 1'b0, 1'b0, 2'd0};
    tv[11] = '{mk(1,4,0,1,0, 1,1,4,0, 0, 0,0,0,0, 1), 2'd0, 2'd0, 1'b1, 1'b0, 2'd2};
    tv[12] = '{mk(1,5,4,1,1, 1,1,5,1, 1, 1,1,4,0, 1), 2'd1, 2'd0, 1'b0, 1'b0, 2'd3};
    tv[13] = '{mk(1,8,8,1,1, 0,1,8,1, 0, 1,1,8,1, 0), 2'd2, 2'd2, 1'b0, 1'b0, 2'd0};
    idle  = mk(0,0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0);
    busy  = mk(1,4,0,1,0, 1,1,4,0, 0, 0,0,0,0, 1);
    clr_v = idle; clr_v.clr = 1'b1;

    do_reset();
    chk("reset_state", 32'(o_state), 32'd0);
    chk("reset_stall_cnt", 32'(o_stall_cycles), 32'd0);
    chk("reset_timeout", 32'(o_mem_timeout), 32'd0);

    for (int i = 0; i < 14; i++) begin
      drive(tv[i].i);
      #1;
      chk($sformatf("tv%0d_fwd1", i), 32'(o_fwd_rs1_sel), 32'(tv[i].f1));
      chk($sformatf("tv%0d_fwd2", i), 32'(o_fwd_rs2_sel), 32'(tv[i].f2));
      chk($sformatf("tv%0d_stall", i), 32'(o_stall_alu), 32'(tv[i].st));
      chk($sformatf("tv%0d_force", i), 32'(o_force_stall_alu), 32'(tv[i].fs));
      @(posedge i_clk);
      mdl_tick(tv[i].i);
      #1;
      chk($sformatf("tv%0d_state", i), 32'(o_state), 32'(tv[i].ns));
      chk_regs();
    end

    // load-use hazard resolves into an M forward on the next cycle
    do_reset();
    cycle(tv[1].i);
    chk("lw_state", 32'(o_state), 32'd1);
    cycle(tv[2].i);
    chk("lw_fwd2", 32'(o_fwd_rs2_sel), 32'd2);
    chk("lw_stall_cnt", 32'(o_stall_cycles), 32'd1);

    // busy + hazard for 3 cycles, then redirect while still busy
    cycle(clr_v);
    for (int k = 0; k < 3; k++) begin
      cycle(busy);
      chk("memw_stall", 32'(o_stall_alu), 32'd1);
      chk("memw_force", 32'(o_force_stall_alu), 32'd0);
    end
    chk("memw_state", 32'(o_state), 32'd2);
    chk("memw_cnt", 32'(o_stall_cycles), 32'd3);
    x = busy; x.chg = 1'b1;
    cycle(x);
    chk("redir_stall", 32'(o_stall_alu | o_force_stall_alu), 32'd0);
    chk("redir_state", 32'(o_state), 32'd3);
    chk("redir_flush", 32'(o_flush_count), 32'd1);

    // watchdog trips on the 4th busy edge and stays set until cleared
    cycle(clr_v);
    for (int k = 1; k <= 6; k++) begin
      cycle(busy);
      chk($sformatf("wd_edge%0d", k), 32'(o_mem_timeout), (k >= TIMEOUT) ? 32'd1 : 32'd0);
    end
    cycle(idle);
    chk("wd_sticky", 32'(o_mem_timeout), 32'd1);
    cycle(clr_v);
    chk("clr_timeout", 32'(o_mem_timeout), 32'd0);
    chk("clr_stall_cnt", 32'(o_stall_cycles), 32'd0);
    chk("clr_flush_cnt", 32'(o_flush_count), 32'd0);

    // async reset in the middle of a memory wait
    cycle(busy);
    cycle(busy);
    drive(busy);
    i_rst = 1'b1;
    #1;
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_stall_cnt", 32'(o_stall_cycles), 32'd0);
    chk("rst_timeout", 32'(o_mem_timeout), 32'd0);
    chk("rst_stall_out", 32'(o_stall_alu | o_force_stall_alu), 32'd0);
    @(posedge i_clk);
    #1;
    chk("rst_held_state", 32'(o_state), 32'd0);
    chk("rst_held_stall", 32'(o_stall_alu), 32'd0);
    i_rst = 1'b0;
    m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 1'b0;

    for (int n = 0; n < 600; n++) begin
      x = mk(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      x.clr = 1'($urandom_range(0, 39) == 0);
      cycle(x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
